// File: rtl/register_bank_reader_if.sv
// register_bank_reader_if
//   Groups the control, register-bank read bus and downstream stream
//   signals of register_bank_reader.
//   Control    : start, base_addr, count (to reader); busy, done (from reader)
//   Bank bus   : rd_en, rd_addr (from reader); rd_data (to reader, one cycle
//                after rd_en)
//   Stream     : m_data, m_valid (from reader); m_ready (to reader)
//   Optional   : m_parity (from reader), present only when
//                REGISTER_BANK_READER_PARITY_EN is defined.
//   Modports   : master = the reader itself, slave = its environment.
interface register_bank_reader_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              done;
`ifdef REGISTER_BANK_READER_PARITY_EN
  logic              m_parity;
`endif

  modport master (
    input  start, base_addr, count, rd_data, m_ready,
    output rd_en, rd_addr, m_data, m_valid, busy, done
`ifdef REGISTER_BANK_READER_PARITY_EN
    , output m_parity
`endif
  );

  modport slave (
    output start, base_addr, count, rd_data, m_ready,
    input  rd_en, rd_addr, m_data, m_valid, busy, done
`ifdef REGISTER_BANK_READER_PARITY_EN
    , input m_parity
`endif
  );
endinterface

// File: rtl/register_bank_reader.sv
// register_bank_reader
//   Burst reader for a register bank with one-cycle read latency. On start
//   (in IDLE) it reads count consecutive registers from base_addr (address
//   wraps modulo 2^ADDR_W) and presents each word downstream with a
//   valid/ready handshake. One word per three cycles at best:
//   ISSUE (rd_en) -> WAIT (data returns) -> PRESENT (m_valid until accepted).
//   count = 0 is a no-op that only pulses done.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - register_bank_reader_if.master (start/base_addr/count,
//            rd_en/rd_addr/rd_data, m_data/m_valid/m_ready, busy, done,
//            optional m_parity)
//
//   Optional feature macro: REGISTER_BANK_READER_PARITY_EN adds m_parity,
//   the XOR of the captured word, registered alongside m_data.
module register_bank_reader #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  register_bank_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              done_q, done_d;
`ifdef REGISTER_BANK_READER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
`ifdef REGISTER_BANK_READER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef REGISTER_BANK_READER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    data_d   = data_q;
    done_d   = 1'b0;
`ifdef REGISTER_BANK_READER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            addr_d   = bus.base_addr;
            remain_d = bus.count;
            state_d  = ISSUE;
          end else begin
            // Empty burst: acknowledge with done only, no bank access.
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Bank data is valid now, one cycle after the rd_en strobe.
        data_d  = bus.rd_data;
`ifdef REGISTER_BANK_READER_PARITY_EN
        parity_d = ^bus.rd_data;
`endif
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.m_ready) begin
          if (remain_q > CNT_ONE) begin
            addr_d   = addr_q + ADDR_ONE;  // natural wrap modulo 2^ADDR_W
            remain_d = remain_q - CNT_ONE;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;  // lands in the cycle m_valid drops
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from registers, so m_valid has no
  // combinational path from m_ready.
  assign bus.rd_en   = (state_q == ISSUE);
  assign bus.rd_addr = addr_q;
  assign bus.m_data  = data_q;
  assign bus.m_valid = (state_q == PRESENT);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
`ifdef REGISTER_BANK_READER_PARITY_EN
  assign bus.m_parity = parity_q;
`endif

endmodule

// File: tb/tb_register_bank_reader.sv
// tb_register_bank_reader
//   Directed bench for register_bank_reader. A bank model holds
//   reg[i] = i*17 and answers rd_en one cycle later. Expected read addresses
//   and delivered words are queued when a burst is requested; a compare
//   process checks every read strobe and every presented word against them
//   on each falling edge. Literal expectations pin the model.
module tb_register_bank_reader;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_bank_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  register_bank_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] bank [NREG];
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  logic [7:0] exp_data [$];
  logic [3:0] exp_addr [$];
  logic [7:0] got_data [$];
  logic [3:0] got_addr [$];
  logic [7:0] pop_d;
  logic [3:0] pop_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Register bank: data for the strobed address appears one cycle later;
  // otherwise a filler value so a mistimed capture is visible.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= bank[bus.rd_addr];
    else                    bus.rd_data <= 8'hEE;
  end

  // Compare process.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.rd_en === 1'b1) begin
        rd_cnt++;
        if (exp_addr.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_en_unexpected actual=rd_en@%0d required=no_read", bus.rd_addr);
        end else begin
          chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr[0]));
          got_addr.push_back(bus.rd_addr);
          pop_a = exp_addr.pop_front();
        end
      end
      if (bus.m_valid === 1'b1) begin
        if (exp_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL m_valid_unexpected actual=0x%0h required=no_word", bus.m_data);
        end else begin
          chk("m_data", 32'(bus.m_data), 32'(exp_data[0]));
`ifdef REGISTER_BANK_READER_PARITY_EN
          chk("m_parity", 32'(bus.m_parity), 32'(^exp_data[0]));
`endif
          if (bus.m_ready === 1'b1) begin
            got_data.push_back(bus.m_data);
            pop_d = exp_data.pop_front();
          end
        end
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_logs();
    got_data.delete();
    got_addr.delete();
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic start_burst(input int base, input int cnt, input bit model);
    bus.start     = 1'b1;
    bus.base_addr = 4'(base);
    bus.count     = 5'(cnt);
    if (model) begin
      for (int i = 0; i < cnt; i++) begin
        exp_addr.push_back(4'((base + i) % NREG));
        exp_data.push_back(bank[(base + i) % NREG]);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input bit random_ready);
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || exp_data.size() != 0) && n < 400) begin
      if (random_ready) bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    bus.m_ready = 1'b1;
    chk("burst_timeout", 32'(n >= 400), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

`ifdef REGISTER_BANK_READER_PARITY_EN
  task automatic parity_case(input logic [7:0] val, input logic req);
    int n;
    bank[0] = val;
    bus.m_ready = 1'b0;
    start_burst(0, 1, 1);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("parity_literal", 32'(bus.m_parity), 32'(req));
    bus.m_ready = 1'b1;
    wait_idle(0);
    bank[0] = 8'h00;
  endtask
`endif

  initial begin
    int dc, rc, n;
    for (int i = 0; i < NREG; i++) bank[i] = 8'(i * 17);
    bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.m_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Reset acts before any clock edge.
    chk("reset_rd_en",   32'(bus.rd_en),   32'd0);
    chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset_busy",    32'(bus.busy),    32'd0);
    chk("reset_done",    32'(bus.done),    32'd0);
    chk("reset_m_data",  32'(bus.m_data),  32'd0);
    chk("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Burst base=2 count=3 with latency pinned cycle by cycle.
    clear_logs(); dc = done_cnt; rc = rd_cnt;
    bus.start = 1'b1; bus.base_addr = 4'd2; bus.count = 5'd3;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(4'(2 + i));
      exp_data.push_back(bank[2 + i]);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("lat_k1_rd_en",   32'(bus.rd_en),   32'd1);
    chk("lat_k1_m_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    chk("lat_k2_rd_en",   32'(bus.rd_en),   32'd0);
    @(negedge clk);
    chk("lat_k3_m_valid", 32'(bus.m_valid), 32'd1);
    chk("lat_k3_m_data",  32'(bus.m_data),  32'h22);
    @(posedge clk); #1;
    wait_idle(0);
    chk("b1_words", 32'(got_data.size()), 32'd3);
    chk("b1_word0", 32'((got_data.size() > 0) ? got_data[0] : 8'hFF), 32'h22);
    chk("b1_word1", 32'((got_data.size() > 1) ? got_data[1] : 8'hFF), 32'h33);
    chk("b1_word2", 32'((got_data.size() > 2) ? got_data[2] : 8'hFF), 32'h44);
    chk("b1_done",  32'(done_cnt - dc), 32'd1);
    chk("b1_reads", 32'(rd_cnt - rc),   32'd3);
    $display("txn burst base=2 count=3 words=%0d", got_data.size());

    // Wrapping burst base=14 count=4.
    clear_logs(); dc = done_cnt;
    start_burst(14, 4, 1);
    wait_idle(0);
    chk("wrap_words", 32'(got_data.size()), 32'd4);
    chk("wrap_a0", 32'((got_addr.size() > 0) ? got_addr[0] : 4'd9), 32'd14);
    chk("wrap_a1", 32'((got_addr.size() > 1) ? got_addr[1] : 4'd9), 32'd15);
    chk("wrap_a2", 32'((got_addr.size() > 2) ? got_addr[2] : 4'd9), 32'd0);
    chk("wrap_a3", 32'((got_addr.size() > 3) ? got_addr[3] : 4'd9), 32'd1);
    chk("wrap_done", 32'(done_cnt - dc), 32'd1);
    $display("txn burst base=14 count=4 words=%0d", got_data.size());

    // Backpressure: hold m_ready low for 5 cycles in PRESENT.
    clear_logs(); rc = rd_cnt;
    bus.m_ready = 1'b0;
    start_burst(5, 2, 1);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
      chk("stall_m_data",  32'(bus.m_data),  32'h55);
      chk("stall_rd_en",   32'(bus.rd_en),   32'd0);
    end
    chk("stall_reads", 32'(rd_cnt - rc), 32'd1);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_idle(0);
    chk("stall_words", 32'(got_data.size()), 32'd2);
    $display("txn burst base=5 count=2 stalled words=%0d", got_data.size());

    // count = 0: done only.
    dc = done_cnt; rc = rd_cnt;
    start_burst(3, 0, 1);
    @(negedge clk);
    chk("zero_busy",  32'(bus.busy),  32'd0);
    chk("zero_done1", 32'(bus.done),  32'd1);
    @(negedge clk);
    chk("zero_done2", 32'(bus.done),  32'd0);
    @(posedge clk); #1;
    chk("zero_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("zero_reads",    32'(rd_cnt - rc),   32'd0);
    $display("txn burst count=0 done_pulses=%0d", done_cnt - dc);

    // Full-bank burst with random backpressure.
    clear_logs(); dc = done_cnt;
    start_burst(0, 16, 1);
    wait_idle(1);
    chk("full_words", 32'(got_data.size()), 32'd16);
    chk("full_last",  32'((got_data.size() > 15) ? got_data[15] : 8'h00), 32'hFF);
    chk("full_done",  32'(done_cnt - dc), 32'd1);
    $display("txn burst base=0 count=16 words=%0d", got_data.size());

    // start while busy is ignored.
    clear_logs(); rc = rd_cnt;
    start_burst(4, 2, 1);
    start_burst(9, 5, 0);
    wait_idle(0);
    chk("busy_ign_words", 32'(got_data.size()), 32'd2);
    chk("busy_ign_reads", 32'(rd_cnt - rc),     32'd2);
    $display("txn burst base=4 count=2 with ignored start words=%0d", got_data.size());

    // Reset mid-burst after two words.
    clear_logs();
    start_burst(0, 8, 1);
    n = 0;
    while (got_data.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    #2 rst = 1'b1;
    #1;
    chk("abort_rd_en",   32'(bus.rd_en),   32'd0);
    chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
    chk("abort_busy",    32'(bus.busy),    32'd0);
    chk("abort_m_data",  32'(bus.m_data),  32'd0);
    chk("abort_rd_addr", 32'(bus.rd_addr), 32'd0);
    exp_addr.delete(); exp_data.delete();
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    chk("abort_idle",    32'(bus.busy),      32'd0);
    clear_logs();
    start_burst(0, 1, 1);
    wait_idle(0);
    chk("restart_words", 32'(got_data.size()), 32'd1);
    chk("restart_word0", 32'((got_data.size() > 0) ? got_data[0] : 8'hFF), 32'h00);
    chk("restart_done",  32'(done_cnt - dc), 32'd1);
    $display("txn reset mid-burst then base=0 count=1 words=%0d", got_data.size());

`ifdef REGISTER_BANK_READER_PARITY_EN
    parity_case(8'h07, 1'b1);
    $display("txn parity rd_data=0x07");
    parity_case(8'h03, 1'b0);
    $display("txn parity rd_data=0x03");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/register_bank_reader.md
REGISTER_BANK_READER -- requirements
Module: register_bank_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the read-data path in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width, giving 2^ADDR_W addressable registers.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr, input, ADDR_W: address of the first register to read, sampled with start.
REQ-007 SHALL have port count, input, ADDR_W+1: number of words to read, sampled with start; 0 means no-op.
REQ-008 SHALL have port rd_en, output, 1: read strobe to the register bank.
REQ-009 SHALL have port rd_addr, output, ADDR_W: read address, valid while rd_en is high.
REQ-010 SHALL have port rd_data, input, WIDTH: register bank output, valid exactly one cycle after rd_en.
REQ-011 SHALL have port m_data, output, WIDTH: word delivered downstream.
REQ-012 SHALL have port m_valid, output, 1: m_data is valid.
REQ-013 SHALL have port m_ready, input, 1: downstream accepts the word.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse marking burst completion.
REQ-016 SHALL have port m_parity, output, 1: even parity of m_data; present only when the macro in REQ-034 is defined.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and PRESENT.
REQ-018 IDLE, on start with count≠0: SHALL latch base_addr and count, then go to ISSUE.
REQ-019 IDLE, on start with count=0: SHALL stay in IDLE, issue no rd_en, and pulse done in the next cycle.
REQ-020 ISSUE SHALL drive rd_en=1 and rd_addr=current address for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL drive rd_en=0 and capture rd_data into m_data on the closing edge, then go to PRESENT.
REQ-022 PRESENT SHALL hold m_valid=1 with m_data stable until the handshake (m_valid and m_ready high in the same cycle).
REQ-023 PRESENT, on handshake with remaining count >1: SHALL increment the address modulo 2^ADDR_W, decrement the remaining count, and go to ISSUE.
REQ-024 PRESENT, on handshake with remaining count =1: SHALL go to IDLE and pulse done for one cycle, in the cycle m_valid falls.
REQ-025 Timing: with start sampled at edge k, rd_en SHALL be high in cycle k+1 and m_valid SHALL rise in cycle k+3; peak throughput is 1 word per 3 cycles.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 The address SHALL wrap past 2^ADDR_W-1 to 0 with no error.
REQ-028 count up to 2^ADDR_W SHALL be accepted, so that every register is read once.
REQ-029 m_ready SHALL be ignored outside PRESENT; m_valid SHALL never depend combinationally on m_ready.

Reset
REQ-030 Asserting rst SHALL immediately force state=IDLE and rd_en, m_valid, busy, done, m_data, rd_addr and m_parity to 0, without waiting for clk.
REQ-031 rst asserted mid-burst SHALL abort the burst with no done pulse; the first start after release SHALL begin a fresh burst.
REQ-032 Reset release SHALL be synchronous to clk in the system; the block SHALL add no synchronizer.

Configuration
REQ-033 SHALL use macro REGISTER_BANK_READER_PARITY_EN.
REQ-034 Macro defined: SHALL add port m_parity, computed as the XOR of rd_data and registered alongside m_data with identical timing and hold behaviour.
REQ-035 Macro undefined: SHALL omit port m_parity and all parity logic; all other behaviour SHALL be unchanged.

Verification
REQ-036 Bank holds reg[i]=i*17; start with base_addr=2, count=3, m_ready=1 -> m_data 0x22, 0x33, 0x44 in order; done pulses once; rd_en seen 3 times.
REQ-037 base_addr=14, count=4, WIDTH=8, ADDR_W=4 -> rd_addr sequence 14, 15, 0, 1; 4 words delivered.
REQ-038 m_ready held low 5 cycles in PRESENT -> m_valid stays 1 and m_data stays constant for all 5 cycles; no new rd_en until the handshake.
REQ-039 start with count=0 -> no rd_en, busy stays 0, done high for exactly 1 cycle.
REQ-040 rst pulsed mid-burst (count=8, after 2 words) -> all outputs 0 asynchronously, no done; a new start with base_addr=0, count=1 -> delivers reg[0].
REQ-041 Macro defined, rd_data=0x07 -> m_parity=1; rd_data=0x03 -> m_parity=0; with the macro undefined the design elaborates without m_parity.
